// File: rtl/nes_bus_sdram_bridge.sv
// nes_bus_sdram_bridge
//   Bridges NUM_CH asynchronous NES-side byte buses (PRG, CHR, ...) onto a
//   single 16-bit SDRAM controller port that uses a req/ack toggle handshake.
//   Each channel has a control synchroniser, a Gray-coded address stability
//   qualifier and a read-data word latch. A round-robin arbiter issues one
//   SDRAM transaction at a time.
//
// Ports
//   clk_i             system / SDRAM controller clock
//   rst_i             synchronous active-high reset
//   ram_req_o         request toggle (not reset; an in-flight transfer drains)
//   ram_ack_i         acknowledge toggle from the controller
//   ram_we_o          1 = write, 0 = read
//   ram_addr_o        SDRAM word address (byte address >> 1)
//   ram_data_write_o  write data, byte replicated on both halves
//   ram_wm_o          write byte mask, 1 = byte not written
//   ram_data_read_i   read data from the controller
//   addr_i            per-channel byte address, channel n at [n*ADDR_BITS +: ADDR_BITS]
//   data_in_i         per-channel write byte, channel n at [n*8 +: 8]
//   data_out_o        per-channel read byte, channel n at [n*8 +: 8]
//   ce_i / oe_i / we_i  per-channel chip enable, output enable (active low),
//                     write enable (active high)
//   busy_o            a transaction is outstanding (req != ack)
//
// Optional feature: define NES_BRIDGE_RDCACHE_EN to add a one-word read tag
// per channel so repeated reads of the same word complete without SDRAM.

module nes_bus_sdram_bridge #(
  parameter int NUM_CH        = 2,
  parameter int ADDR_BITS     = 23,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        ram_req_o,
  input  logic                        ram_ack_i,
  output logic                        ram_we_o,
  output logic [ADDR_BITS-2:0]        ram_addr_o,
  output logic [15:0]                 ram_data_write_o,
  output logic [1:0]                  ram_wm_o,
  input  logic [15:0]                 ram_data_read_i,
  input  logic [NUM_CH*ADDR_BITS-1:0] addr_i,
  input  logic [NUM_CH*8-1:0]         data_in_i,
  output logic [NUM_CH*8-1:0]         data_out_o,
  input  logic [NUM_CH-1:0]           ce_i,
  input  logic [NUM_CH-1:0]           oe_i,
  input  logic [NUM_CH-1:0]           we_i,
  output logic                        busy_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 3;
  localparam int WA_W  = ADDR_BITS - 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Decodes the upper (word) part of a Gray address. Binary bit i only
  // depends on Gray bits at or above i, so the word bits decode on their own.
  function automatic logic [WA_W-1:0] gray2word(input logic [WA_W-1:0] g);
    logic [WA_W-1:0] b;
    b[WA_W-1] = g[WA_W-1];
    for (int i = WA_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0]           rd_sync_q   [SYNC_STAGES];
  logic [NUM_CH-1:0]           wr_sync_q   [SYNC_STAGES];
  logic [NUM_CH*ADDR_BITS-1:0] gray_sync_q [SYNC_STAGES];
  logic [NUM_CH*8-1:0]         din_sync_q  [SYNC_STAGES];
  logic [NUM_CH-1:0]           wr_hist_q;
  logic [NUM_CH*ADDR_BITS-1:0] gray_cmp_q;
  logic [NUM_CH*8-1:0]         din_cmp_q;
  logic [NUM_CH*ADDR_BITS-1:0] gray_in;

  always_comb begin
    gray_in = '0;
    for (int c = 0; c < NUM_CH; c++)
      gray_in[c*ADDR_BITS +: ADDR_BITS] = addr_i[c*ADDR_BITS +: ADDR_BITS] ^
                                          (addr_i[c*ADDR_BITS +: ADDR_BITS] >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        rd_sync_q[s]   <= '0;
        wr_sync_q[s]   <= '0;
        gray_sync_q[s] <= '0;
        din_sync_q[s]  <= '0;
      end
      wr_hist_q  <= '0;
      gray_cmp_q <= '0;
      din_cmp_q  <= '0;
    end else begin
      rd_sync_q[0]   <= ce_i & ~oe_i;
      wr_sync_q[0]   <= ce_i & we_i;
      gray_sync_q[0] <= gray_in;
      din_sync_q[0]  <= data_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        rd_sync_q[s]   <= rd_sync_q[s-1];
        wr_sync_q[s]   <= wr_sync_q[s-1];
        gray_sync_q[s] <= gray_sync_q[s-1];
        din_sync_q[s]  <= din_sync_q[s-1];
      end
      // History stage: aligned with the last cycle wr_s was high, so a
      // trailing-edge write captures the address/data seen while enabled.
      wr_hist_q  <= wr_sync_q[SYNC_STAGES-1];
      gray_cmp_q <= gray_sync_q[SYNC_STAGES-1];
      din_cmp_q  <= din_sync_q[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel read/write qualification
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]     cnt_q       [NUM_CH];
  logic [CNT_W-1:0]     cnt_nx      [NUM_CH];
  logic [WA_W-1:0]      rd_word_now [NUM_CH];
  logic [WA_W-1:0]      rd_word_q   [NUM_CH];
  logic [ADDR_BITS-1:0] wr_addr_now [NUM_CH];
  logic [ADDR_BITS-1:0] wr_addr_q   [NUM_CH];
  logic [7:0]           wr_data_q   [NUM_CH];
  logic [15:0]          word_q      [NUM_CH];
  logic [NUM_CH-1:0]    rd_s, addr_eq, rd_qual, rd_hit, wr_fall;
  logic [NUM_CH-1:0]    rd_done_q, rd_pend_q, wr_pend_q, rd_clr, wr_clr;

`ifdef NES_BRIDGE_RDCACHE_EN
  logic [WA_W-1:0]      tag_q [NUM_CH];
  logic [NUM_CH-1:0]    tag_v_q;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rd_s[c]    = rd_sync_q[SYNC_STAGES-1][c];
      addr_eq[c] = gray_sync_q[SYNC_STAGES-1][c*ADDR_BITS +: ADDR_BITS] ==
                   gray_cmp_q[c*ADDR_BITS +: ADDR_BITS];
      if (rd_s[c] && addr_eq[c])
        cnt_nx[c] = (cnt_q[c] == CNT_W'(STABLE_CYCLES)) ? cnt_q[c] : cnt_q[c] + 1'b1;
      else
        cnt_nx[c] = '0;
      rd_qual[c] = rd_s[c] && addr_eq[c] && !rd_done_q[c] &&
                   (cnt_nx[c] == CNT_W'(STABLE_CYCLES));
      rd_word_now[c] = gray2word(gray_sync_q[SYNC_STAGES-1][c*ADDR_BITS+1 +: WA_W]);
      wr_addr_now[c][ADDR_BITS-1:1] = gray2word(gray_cmp_q[c*ADDR_BITS+1 +: WA_W]);
      wr_addr_now[c][0] = wr_addr_now[c][1] ^ gray_cmp_q[c*ADDR_BITS];
      wr_fall[c] = wr_hist_q[c] && !wr_sync_q[SYNC_STAGES-1][c];
`ifdef NES_BRIDGE_RDCACHE_EN
      rd_hit[c] = tag_v_q[c] && (tag_q[c] == rd_word_now[c]);
`else
      rd_hit[c] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_done_q <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]     <= '0;
        rd_word_q[c] <= '0;
        wr_addr_q[c] <= '0;
        wr_data_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_nx[c];
        // A fall of rd_s or an address change re-arms the channel.
        if (!rd_s[c] || !addr_eq[c]) rd_done_q[c] <= 1'b0;
        else if (rd_qual[c])         rd_done_q[c] <= 1'b1;
        if (rd_qual[c]) rd_word_q[c] <= rd_word_now[c];
        if (wr_fall[c]) begin
          wr_addr_q[c] <= wr_addr_now[c];
          wr_data_q[c] <= din_cmp_q[c*8 +: 8];
        end
      end
      // Set after clear: a new event in the grant cycle is kept.
      rd_pend_q <= (rd_pend_q & ~rd_clr) | (rd_qual & ~rd_hit);
      wr_pend_q <= (wr_pend_q & ~wr_clr) | wr_fall;
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin arbiter and SDRAM port FSM
  // ---------------------------------------------------------------------
  state_t            state_q;
  logic              ram_req_q, ram_we_q, cur_rd_q;
  logic [WA_W-1:0]   ram_addr_q;
  logic [15:0]       ram_dw_q;
  logic [1:0]        ram_wm_q;
  logic [CH_W-1:0]   rr_ptr_q, grant_q, grant_ch, rr_next;
  logic              grant_vld, grant_wr, fire;

  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_vld && (rd_pend_q[c] || wr_pend_q[c])) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
    grant_wr = wr_pend_q[grant_ch];
    rr_next  = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    fire     = (state_q == S_IDLE) && (ram_req_q == ram_ack_i) && grant_vld;
    rd_clr   = '0;
    wr_clr   = '0;
    if (fire && grant_wr)  wr_clr[grant_ch] = 1'b1;
    if (fire && !grant_wr) rd_clr[grant_ch] = 1'b1;
  end

  // state  | meaning
  // S_IDLE | no transaction outstanding, grant next pending request
  // S_WAIT | req toggled, waiting for ack (also entered from reset if in flight)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // ram_req_q is deliberately left alone so an in-flight transfer drains;
      // cur_rd_q = 0 makes its read data be discarded.
      state_q    <= (ram_req_q != ram_ack_i) ? S_WAIT : S_IDLE;
      cur_rd_q   <= 1'b0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_wm_q   <= 2'b11;
      ram_addr_q <= '0;
      ram_dw_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) word_q[c] <= '0;
`ifdef NES_BRIDGE_RDCACHE_EN
      tag_v_q <= '0;
      for (int c = 0; c < NUM_CH; c++) tag_q[c] <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            ram_req_q <= ~ram_req_q;
            grant_q   <= grant_ch;
            rr_ptr_q  <= rr_next;
            cur_rd_q  <= ~grant_wr;
            state_q   <= S_WAIT;
            if (grant_wr) begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= wr_addr_q[grant_ch][ADDR_BITS-1:1];
              ram_dw_q   <= {2{wr_data_q[grant_ch]}};
              ram_wm_q   <= wr_addr_q[grant_ch][0] ? 2'b01 : 2'b10;
`ifdef NES_BRIDGE_RDCACHE_EN
              // Keep every cached copy of this word coherent.
              for (int c = 0; c < NUM_CH; c++) begin
                if (tag_v_q[c] && tag_q[c] == wr_addr_q[grant_ch][ADDR_BITS-1:1]) begin
                  if (wr_addr_q[grant_ch][0]) word_q[c][15:8] <= wr_data_q[grant_ch];
                  else                        word_q[c][7:0]  <= wr_data_q[grant_ch];
                end
              end
`endif
            end else begin
              ram_we_q   <= 1'b0;
              ram_addr_q <= rd_word_q[grant_ch];
            end
          end
        end
        S_WAIT: begin
          if (ram_ack_i == ram_req_q) begin
            if (cur_rd_q) begin
              word_q[grant_q] <= ram_data_read_i;
`ifdef NES_BRIDGE_RDCACHE_EN
              tag_q[grant_q]   <= ram_addr_q;
              tag_v_q[grant_q] <= 1'b1;
`endif
            end
            cur_rd_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_out_o = '0;
    for (int c = 0; c < NUM_CH; c++)
      data_out_o[c*8 +: 8] = addr_i[c*ADDR_BITS] ? word_q[c][15:8] : word_q[c][7:0];
  end

  assign ram_req_o        = ram_req_q;
  assign ram_we_o         = ram_we_q;
  assign ram_addr_o       = ram_addr_q;
  assign ram_data_write_o = ram_dw_q;
  assign ram_wm_o         = ram_wm_q;
  assign busy_o           = ram_req_q != ram_ack_i;

endmodule
